dmem_port_arbiter: RTL

Two-port arbiter that shares the single data memory between the core's load/store path (port 0) and a loader/debug master (port 1). It grants one transaction per cycle with round-robin fairness and supports short locked sequences for read-modify-write. The memory keeps its combinational-read/synchronous-write behaviour, and the arbiter returns read data one cycle after grant. It sits between the core datapath/loader and the data memory inside the single-cycle top.

---
 rtl/dmem_port_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing one combinational-read / synchronous-write data memory
// between the core load/store port (0) and a loader/debug port (1), with bounded locking.
module dmem_port_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_LOCK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
);

    localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic               rvalid0_q, rvalid0_d;
    logic               rvalid1_q, rvalid1_d;
    logic [DATA_W-1:0]  rdata0_q, rdata0_d;
    logic [DATA_W-1:0]  rdata1_q, rdata1_d;

    logic own0;
    logic own1;
    logic win0;
    logic win1;
    logic win_lock;
    logic rd0;
    logic rd1;

    // A lock only holds while its owner keeps requesting; otherwise fall back to normal arbitration.
    always_comb begin
        own0 = (state_q == LOCK0) && req0;
        own1 = (state_q == LOCK1) && req1;
        win0 = 1'b0;
        win1 = 1'b0;
        if (own0) begin
            win0 = 1'b1;
        end else if (own1) begin
            win1 = 1'b1;
        end else if (req0 && req1) begin
            if (rr_ptr_q) begin
                win1 = 1'b1;
            end else begin
                win0 = 1'b1;
            end
        end else if (req0) begin
            win0 = 1'b1;
        end else if (req1) begin
            win1 = 1'b1;
        end
        win_lock = win1 ? lock1 : lock0;
    end

    always_comb begin
        gnt0   = win0 & rst;
        gnt1   = win1 & rst;
        mem_a  = win1 ? addr1 : addr0;
        mem_wd = win1 ? wdata1 : wdata0;
        mem_we = (gnt0 & we0) | (gnt1 & we1);
        rd0    = gnt0 & ~we0;
        rd1    = gnt1 & ~we1;
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_cnt_d = lock_cnt_q;
        if (own0 || own1) begin
            if (win_lock && (lock_cnt_q < CNT_W'(MAX_LOCK - 1))) begin
                lock_cnt_d = lock_cnt_q + CNT_W'(1);
            end else begin
                state_d    = IDLE;
                lock_cnt_d = '0;
                rr_ptr_d   = own0;
            end
        end else if (win0 || win1) begin
            if (win_lock) begin
                state_d    = win0 ? LOCK0 : LOCK1;
                lock_cnt_d = CNT_W'(1);
            end else begin
                state_d    = IDLE;
                lock_cnt_d = '0;
                rr_ptr_d   = win0;
            end
        end else begin
            state_d    = IDLE;
            lock_cnt_d = '0;
        end
    end

    always_comb begin
        rvalid0_d = rd0;
        rvalid1_d = rd1;
        rdata0_d  = rd0 ? mem_rd : rdata0_q;
        rdata1_d  = rd1 ? mem_rd : rdata1_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= 1'b0;
            lock_cnt_q <= '0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_cnt_q <= lock_cnt_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;

endmodule
